acorn128_phase_sequencer: RTL and testbench
===========================================

ACORN128_PHASE_SEQUENCER -- requirements
Module: acorn128_phase_sequencer

Interface
REQ-001 Parameter INIT_STEPS, default 1792, initialization phase length in state-update cycles.
REQ-002 Parameter PAD_STEPS, default 256, padding cycles appended to AD phase and to message phase.
REQ-003 Parameter FINAL_STEPS, default 768, finalization phase length in cycles.
REQ-004 Parameter TIMEOUT_MARGIN, default 16, extra cycles tolerated past expected phase length.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start_in  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-008 encrypt_in  input  1  1 = encrypt, 0 = decrypt; latched with start_in.
REQ-009 abort_in  input  1  synchronous abort of any operation in progress.
REQ-010 ad_len_in  input  64  associated-data length in bits; latched with start_in.
REQ-011 msg_len_in  input  64  message length in bits; latched with start_in.
REQ-012 done_ip_in, done_pp_in, done_ep_in, done_fp_in  input  1 each  phase-complete flags from the init, AD, encryption and finalization datapaths.
REQ-013 start_ip_out, start_pp_out, start_ep_out, start_fp_out  output  1 each  level enables to the four datapaths.
REQ-014 encrypt_out  output  1  latched mode.
REQ-015 phase_out  output  3  IDLE=0, INIT=1, AD=2, MSG=3, FINAL=4, DONE=5, ERROR=6.
REQ-016 busy_out  output  1  high in INIT, AD, MSG, FINAL.
REQ-017 ready_out  output  1  high in DONE only.
REQ-018 error_out  output  1  high in ERROR only.

Function
REQ-019 States and transitions: IDLE -start_in-> INIT -done_ip_in-> AD -done_pp_in-> MSG -done_ep_in-> FINAL -done_fp_in-> DONE -start_in-> INIT.
REQ-020 Exactly one start_*_out is high in each busy state (INIT->ip, AD->pp, MSG->ep, FINAL->fp); all are low in IDLE, DONE, ERROR.
REQ-021 On a phase transition the old enable drops and the next enable rises on the same clock edge; no gap cycle, no overlap.
REQ-022 done_*_in is honoured only for the current phase; done flags of other phases are ignored.
REQ-023 A 65-bit step counter clears on every state entry and increments once per cycle in busy states.
REQ-024 Expected length per phase: INIT = INIT_STEPS, AD = ad_len + PAD_STEPS, MSG = msg_len + PAD_STEPS, FINAL = FINAL_STEPS; sums computed at 65 bits, no wrap.
REQ-025 start_in while busy is ignored; lengths and mode stay latched until next accepted start.
REQ-026 abort_in in any state forces IDLE next cycle with all enables low; abort_in beats start_in when both high.
REQ-027 ERROR is left only by abort_in or reset; start_in is ignored there.
REQ-028 Zero-length AD or message still runs PAD_STEPS cycles in that phase.
REQ-029 Operation latency from start_in accepted to ready_out = sum of the four actual phase durations + 1 cycle.

Reset
REQ-030 rst low asynchronously forces IDLE, counter 0, latched lengths 0, encrypt_out 0, all start_*_out, busy_out, ready_out, error_out 0.
REQ-031 Reset mid-operation discards the operation; the first start_in after rst rises starts a fresh INIT.

Configuration
REQ-032 Macro ACORN_PHASE_WATCHDOG_EN: when defined, a done flag arriving with counter < expected-1, or counter reaching expected + TIMEOUT_MARGIN without done, moves to ERROR next cycle.
REQ-033 Without ACORN_PHASE_WATCHDOG_EN the sequencer waits indefinitely for each done flag, accepts early done, and ERROR/error_out are never reached (error_out tied 0).

Verification
REQ-034 rst low mid-AD -> all outputs 0 within the same cycle, phase_out=0; after release, start_in -> phase_out=1 next cycle.
REQ-035 start_in, encrypt_in=1, ad_len=128, msg_len=128, datapath models asserting done on the final cycle of 1792/384/384/768 -> ready_out high 3329 cycles after start, encrypt_out=1.
REQ-036 done_pp_in pulsed during INIT -> ignored, still INIT; start_in pulsed during MSG -> ignored, lengths unchanged.
REQ-037 abort_in and start_in together in FINAL -> IDLE next cycle, start_fp_out low, no INIT entry.
REQ-038 With ACORN_PHASE_WATCHDOG_EN, done_ip_in withheld -> error_out high at cycle 1792+16 of INIT; done_ip_in at cycle 10 -> ERROR.
REQ-039 Without ACORN_PHASE_WATCHDOG_EN, same withheld done -> remains INIT for 5000 cycles, error_out 0.

Source files
------------

// File: rtl/acorn128_phase_sequencer.sv
// Phase sequencer for an ACORN-128 core: steps INIT -> AD -> MSG -> FINAL -> DONE.
// Optional per-phase watchdog is built in with `define ACORN_PHASE_WATCHDOG_EN.
module acorn128_phase_sequencer #(
    parameter int unsigned INIT_STEPS     = 1792,
    parameter int unsigned PAD_STEPS      = 256,
    parameter int unsigned FINAL_STEPS    = 768,
    parameter int unsigned TIMEOUT_MARGIN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        encrypt_in,
    input  logic        abort_in,
    input  logic [63:0] ad_len_in,
    input  logic [63:0] msg_len_in,
    input  logic        done_ip_in,
    input  logic        done_pp_in,
    input  logic        done_ep_in,
    input  logic        done_fp_in,
    output logic        start_ip_out,
    output logic        start_pp_out,
    output logic        start_ep_out,
    output logic        start_fp_out,
    output logic        encrypt_out,
    output logic [2:0]  phase_out,
    output logic        busy_out,
    output logic        ready_out,
    output logic        error_out
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StInit  = 3'd1,
        StAd    = 3'd2,
        StMsg   = 3'd3,
        StFinal = 3'd4,
        StDone  = 3'd5,
        StError = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [64:0] cnt_q, cnt_d;
    logic [63:0] ad_len_q, msg_len_q;
    logic        encrypt_q;

    logic        busy;
    logic        accept;
    logic        phase_done;
    logic [64:0] exp_len;
    logic [65:0] limit;
    logic        early_done;
    logic        timed_out;
    logic        wd_trip;

    assign busy   = (state_q == StInit) || (state_q == StAd) ||
                    (state_q == StMsg)  || (state_q == StFinal);
    assign accept = start_in && !abort_in && ((state_q == StIdle) || (state_q == StDone));

    // Only the done flag of the phase currently running is honoured.
    always_comb begin
        phase_done = 1'b0;
        exp_len    = '0;
        case (state_q)
            StInit: begin
                phase_done = done_ip_in;
                exp_len    = 65'(INIT_STEPS);
            end
            StAd: begin
                phase_done = done_pp_in;
                exp_len    = {1'b0, ad_len_q} + 65'(PAD_STEPS);
            end
            StMsg: begin
                phase_done = done_ep_in;
                exp_len    = {1'b0, msg_len_q} + 65'(PAD_STEPS);
            end
            StFinal: begin
                phase_done = done_fp_in;
                exp_len    = 65'(FINAL_STEPS);
            end
            default: ;
        endcase
    end

    // cnt + 1 < exp is cnt < exp - 1 without underflow when exp is 0.
    assign limit      = {1'b0, exp_len} + 66'(TIMEOUT_MARGIN);
    assign early_done = phase_done && ((cnt_q + 65'd1) < exp_len);
    assign timed_out  = busy && !phase_done && ({1'b0, cnt_q} >= limit);

`ifdef ACORN_PHASE_WATCHDOG_EN
    assign wd_trip = early_done || timed_out;
`else
    assign wd_trip = 1'b0;
    logic unused_wd;
    assign unused_wd = early_done ^ timed_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = StIdle;
        end else if (wd_trip) begin
            state_d = StError;
        end else begin
            case (state_q)
                StIdle, StDone: if (start_in)   state_d = StInit;
                StInit:         if (phase_done) state_d = StAd;
                StAd:           if (phase_done) state_d = StMsg;
                StMsg:          if (phase_done) state_d = StFinal;
                StFinal:        if (phase_done) state_d = StDone;
                default: ;
            endcase
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 65'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            ad_len_q  <= '0;
            msg_len_q <= '0;
            encrypt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                ad_len_q  <= ad_len_in;
                msg_len_q <= msg_len_in;
                encrypt_q <= encrypt_in;
            end
        end
    end

    always_comb begin
        start_ip_out = (state_q == StInit);
        start_pp_out = (state_q == StAd);
        start_ep_out = (state_q == StMsg);
        start_fp_out = (state_q == StFinal);
        busy_out     = busy;
        ready_out    = (state_q == StDone);
        encrypt_out  = encrypt_q;
        phase_out    = state_q;
`ifdef ACORN_PHASE_WATCHDOG_EN
        error_out    = (state_q == StError);
`else
        error_out    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_acorn128_phase_sequencer.sv
// Directed bench for acorn128_phase_sequencer; watchdog scenarios follow ACORN_PHASE_WATCHDOG_EN.
module tb_acorn128_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic        encrypt_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [63:0] ad_len_in = '0;
    logic [63:0] msg_len_in = '0;
    logic        done_ip_in = 1'b0;
    logic        done_pp_in = 1'b0;
    logic        done_ep_in = 1'b0;
    logic        done_fp_in = 1'b0;
    logic        start_ip_out, start_pp_out, start_ep_out, start_fp_out;
    logic        encrypt_out, busy_out, ready_out, error_out;
    logic [2:0]  phase_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    acorn128_phase_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .encrypt_in   (encrypt_in),
        .abort_in     (abort_in),
        .ad_len_in    (ad_len_in),
        .msg_len_in   (msg_len_in),
        .done_ip_in   (done_ip_in),
        .done_pp_in   (done_pp_in),
        .done_ep_in   (done_ep_in),
        .done_fp_in   (done_fp_in),
        .start_ip_out (start_ip_out),
        .start_pp_out (start_pp_out),
        .start_ep_out (start_ep_out),
        .start_fp_out (start_fp_out),
        .encrypt_out  (encrypt_out),
        .phase_out    (phase_out),
        .busy_out     (busy_out),
        .ready_out    (ready_out),
        .error_out    (error_out)
    );

    always #5 clk = ~clk;

    // {ip, pp, ep, fp, busy, ready, error, encrypt, phase[2:0]}
    logic [10:0] obs;
    assign obs = {start_ip_out, start_pp_out, start_ep_out, start_fp_out,
                  busy_out, ready_out, error_out, encrypt_out, phase_out};

    function automatic logic [10:0] exp_outs(input logic [2:0] ph, input logic enc);
        logic [3:0] en;
        logic       bsy;
        en  = {ph == 3'd1, ph == 3'd2, ph == 3'd3, ph == 3'd4};
        bsy = (ph >= 3'd1) && (ph <= 3'd4);
        return {en, bsy, ph == 3'd5, ph == 3'd6, enc, ph};
    endfunction

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic enc, input logic [63:0] ad, input logic [63:0] msg);
        start_in   = 1'b1;
        encrypt_in = enc;
        ad_len_in  = ad;
        msg_len_in = msg;
        step();
        start_in   = 1'b0;
        encrypt_in = 1'b0;
        ad_len_in  = '0;
        msg_len_in = '0;
    endtask

    // Phase `which` (0=ip..3=fp) lasts n cycles from now; done is asserted on its last cycle.
    task automatic run_phase(input int n, input int which, input logic enc, input string nm);
        logic [10:0] e;
        repeat (n - 1) step();
        e = exp_outs(3'(which + 1), enc);
        total_cnt++;
        if (obs !== e) $display("FAIL %s_before_done: got %b want %b", nm, obs, e);
        else pass_cnt++;
        case (which)
            0: done_ip_in = 1'b1;
            1: done_pp_in = 1'b1;
            2: done_ep_in = 1'b1;
            default: done_fp_in = 1'b1;
        endcase
        step();
        {done_ip_in, done_pp_in, done_ep_in, done_fp_in} = 4'b0;
        e = exp_outs(3'(which + 2), enc);
        total_cnt++;
        if (obs !== e) $display("FAIL %s_after_done: got %b want %b", nm, obs, e);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #4;
        total_cnt++;
        if (obs !== 11'b0) $display("FAIL reset_outputs: got %b want %b", obs, 11'b0);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
        total_cnt++;
        if (obs !== 11'b0) $display("FAIL idle_after_reset: got %b want %b", obs, 11'b0);
        else pass_cnt++;
    endtask

    // Full encrypt run: 1 + 1792 + 384 + 384 + 768 = 3329 edges after start is raised.
    task automatic test_full_op();
        start_op(1'b1, 64'd128, 64'd128);
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b1)) $display("FAIL full_init_entry: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b1));
        else pass_cnt++;
        run_phase(1792, 0, 1'b1, "full_init");
        run_phase(384, 1, 1'b1, "full_ad");
        run_phase(384, 2, 1'b1, "full_msg");
        run_phase(768, 3, 1'b1, "full_final");
        step();
        total_cnt++;
        if (obs !== exp_outs(3'd5, 1'b1)) $display("FAIL full_done_hold: got %b want %b",
                                                   obs, exp_outs(3'd5, 1'b1));
        else pass_cnt++;
    endtask

    // Back-to-back start from DONE in decrypt mode, with foreign done flags and a start in MSG.
    task automatic test_ignore();
        start_op(1'b0, 64'd64, 64'd32);
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b0)) $display("FAIL b2b_init_entry: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b0));
        else pass_cnt++;
        {done_pp_in, done_ep_in, done_fp_in} = 3'b111;
        step();
        {done_pp_in, done_ep_in, done_fp_in} = 3'b000;
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b0)) $display("FAIL ignore_in_init: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b0));
        else pass_cnt++;
        run_phase(1791, 0, 1'b0, "ign_init");
        {done_ip_in, done_ep_in, done_fp_in} = 3'b111;
        step();
        {done_ip_in, done_ep_in, done_fp_in} = 3'b000;
        total_cnt++;
        if (obs !== exp_outs(3'd2, 1'b0)) $display("FAIL ignore_in_ad: got %b want %b",
                                                   obs, exp_outs(3'd2, 1'b0));
        else pass_cnt++;
        run_phase(319, 1, 1'b0, "ign_ad");
        start_in   = 1'b1;
        encrypt_in = 1'b1;
        ad_len_in  = 64'd5;
        msg_len_in = 64'd5;
        step();
        start_in   = 1'b0;
        encrypt_in = 1'b0;
        total_cnt++;
        if (obs !== exp_outs(3'd3, 1'b0)) $display("FAIL start_in_msg: got %b want %b",
                                                   obs, exp_outs(3'd3, 1'b0));
        else pass_cnt++;
        run_phase(287, 2, 1'b0, "ign_msg");
    endtask

    // Currently in FINAL: abort together with start must land in IDLE and stay there.
    task automatic test_abort();
        repeat (3) step();
        abort_in = 1'b1;
        start_in = 1'b1;
        step();
        abort_in = 1'b0;
        start_in = 1'b0;
        total_cnt++;
        if (obs !== exp_outs(3'd0, 1'b0)) $display("FAIL abort_in_final: got %b want %b",
                                                   obs, exp_outs(3'd0, 1'b0));
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== exp_outs(3'd0, 1'b0)) $display("FAIL no_init_after_abort: got %b want %b",
                                                   obs, exp_outs(3'd0, 1'b0));
        else pass_cnt++;
        abort_in = 1'b1;
        start_in = 1'b1;
        step();
        abort_in = 1'b0;
        start_in = 1'b0;
        total_cnt++;
        if (obs !== exp_outs(3'd0, 1'b0)) $display("FAIL abort_beats_start_idle: got %b want %b",
                                                   obs, exp_outs(3'd0, 1'b0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_ad();
        start_op(1'b1, 64'd0, 64'd0);
        run_phase(1792, 0, 1'b1, "rst_init");
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 11'b0) $display("FAIL async_reset_mid_ad: got %b want %b", obs, 11'b0);
        else pass_cnt++;
        step();
        rst = 1'b1;
        step();
        start_op(1'b0, 64'd0, 64'd0);
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b0)) $display("FAIL init_after_reset: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b0));
        else pass_cnt++;
    endtask

`ifndef ACORN_PHASE_WATCHDOG_EN
    // Currently in INIT with done withheld.
    task automatic test_no_watchdog();
        repeat (5000) step();
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b0)) $display("FAIL wait_forever_init: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b0));
        else pass_cnt++;
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        total_cnt++;
        if (obs !== exp_outs(3'd0, 1'b0)) $display("FAIL abort_from_init: got %b want %b",
                                                   obs, exp_outs(3'd0, 1'b0));
        else pass_cnt++;
    endtask
`else
    // Currently in INIT (counter 0) with done withheld: trips when the counter reaches 1808.
    task automatic test_watchdog();
        repeat (1808) step();
        total_cnt++;
        if (obs !== exp_outs(3'd1, 1'b0)) $display("FAIL wd_before_timeout: got %b want %b",
                                                   obs, exp_outs(3'd1, 1'b0));
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs !== exp_outs(3'd6, 1'b0)) $display("FAIL wd_timeout: got %b want %b",
                                                   obs, exp_outs(3'd6, 1'b0));
        else pass_cnt++;
        start_op(1'b1, 64'd0, 64'd0);
        total_cnt++;
        if (obs !== exp_outs(3'd6, 1'b0)) $display("FAIL start_in_error: got %b want %b",
                                                   obs, exp_outs(3'd6, 1'b0));
        else pass_cnt++;
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        start_op(1'b1, 64'd0, 64'd0);
        repeat (10) step();
        done_ip_in = 1'b1;
        step();
        done_ip_in = 1'b0;
        total_cnt++;
        if (obs !== exp_outs(3'd6, 1'b1)) $display("FAIL wd_early_done: got %b want %b",
                                                   obs, exp_outs(3'd6, 1'b1));
        else pass_cnt++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_op();
        test_ignore();
        test_abort();
        test_reset_mid_ad();
`ifndef ACORN_PHASE_WATCHDOG_EN
        test_no_watchdog();
`else
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
